// File: rtl/pds_pkg.sv
// Shared types and constants for the per-port packet queue.
// Holds the byte width, the input FSM state enum and the stored entry layout.
package pds_pkg;

    localparam int BYTE_W = 8;
    localparam int ENTRY_W = BYTE_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DISCARD
    } pds_state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [BYTE_W-1:0] data;
    } pds_entry_t;

    // Saturating add used by both statistics counters.
    function automatic logic [7:0] sat_add(input logic [7:0] a,
                                           input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/pds_buf_ram.sv
// DEPTH x 10-bit packet storage: one synchronous write, one asynchronous read.
// Ports: clk, we/waddr/wdata (write side), raddr/rdata (combinational read).
module pds_buf_ram
    import pds_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pds_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output pds_entry_t    rdata
);

    // Contents are never reset; pointers alone define what is valid.
    pds_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pds_port_queue.sv
// Per-port packet queue: stores whole packets addressed to PORTNO, drops others.
// Ports: clk, rst (sync, active-high); in_* byte stream (never stalled);
// out_* first-word fall-through committed bytes with out_ready; pkt_cnt, drop_cnt.
module pds_port_queue
    import pds_pkg::*;
#(
    parameter int PORTNO = 1,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [BYTE_W-1:0] out_data,
    output logic [7:0]        pkt_cnt,
    output logic [7:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [1:0]    PORT    = PORTNO[1:0];

    pds_state_t    state, state_n;
    logic [PW-1:0] wr, wr_n;
    logic [PW-1:0] commit, commit_n;
    logic [PW-1:0] rd;
    logic [PW-1:0] base;
    logic          base_full;
    logic          full;
    logic          do_sop;
    logic          we;
    logic [AW-1:0] waddr;
    pds_entry_t    wdata;
    pds_entry_t    rdata;
    logic          pkt_inc;
    logic [1:0]    drop_inc;
    logic          rd_fire;

    // Occupancy counts uncommitted bytes too, so an in-flight packet can
    // never overrun data that is still waiting to be read.
    assign full    = (wr - rd) == DEPTH_P;
    assign rd_fire = out_valid & out_ready;

    always_comb begin
        state_n   = state;
        wr_n      = wr;
        commit_n  = commit;
        we        = 1'b0;
        waddr     = wr[AW-1:0];
        wdata     = '{sop: in_sop, eop: in_eop, data: in_data};
        pkt_inc   = 1'b0;
        drop_inc  = 2'd0;
        base      = wr;
        base_full = 1'b0;
        do_sop    = 1'b0;

        if (in_valid) begin
            unique case (state)
                IDLE: begin
                    do_sop = in_sop;
                end
                ACCEPT: begin
                    if (in_sop) begin
                        // Truncated packet: discard its bytes, then
                        // treat this byte as a fresh start of packet.
                        base     = commit;
                        wr_n     = commit;
                        drop_inc = 2'd1;
                        do_sop   = 1'b1;
                    end else if (full) begin
                        wr_n     = commit;
                        drop_inc = 2'd1;
                        state_n  = in_eop ? IDLE : DISCARD;
                    end else begin
                        we   = 1'b1;
                        wr_n = wr + 1'b1;
                        if (in_eop) begin
                            commit_n = wr + 1'b1;
                            pkt_inc  = 1'b1;
                            state_n  = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (in_sop) begin
                        do_sop = 1'b1;
                    end else if (in_eop) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (do_sop) begin
                base_full = (base - rd) == DEPTH_P;
                if (in_data[1:0] != PORT) begin
                    state_n = in_eop ? IDLE : DISCARD;
                end else if (base_full) begin
                    drop_inc = drop_inc + 2'd1;
                    state_n  = in_eop ? IDLE : DISCARD;
                end else begin
                    we    = 1'b1;
                    waddr = base[AW-1:0];
                    wr_n  = base + 1'b1;
                    if (in_eop) begin
                        commit_n = base + 1'b1;
                        pkt_inc  = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        state_n  = ACCEPT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr       <= '0;
            commit   <= '0;
            rd       <= '0;
            pkt_cnt  <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            state    <= state_n;
            wr       <= wr_n;
            commit   <= commit_n;
            if (rd_fire) begin
                rd <= rd + 1'b1;
            end
            pkt_cnt  <= sat_add(pkt_cnt, {1'b0, pkt_inc});
            drop_cnt <= sat_add(drop_cnt, drop_inc);
        end
    end

    pds_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd[AW-1:0]),
        .rdata (rdata)
    );

    // Only bytes behind the commit pointer are ever presented.
    assign out_valid = rd != commit;
    assign out_sop   = rdata.sop;
    assign out_eop   = rdata.eop;
    assign out_data  = rdata.data;

endmodule

// File: doc/pds_port_queue.md
PDS_PORT_QUEUE -- requirements
Module: pds_port_queue

Interface
REQ-001 The block SHALL have parameter PORTNO, default 1: destination port this queue accepts (0..3).
REQ-002 The block SHALL have parameter DEPTH, default 16: storage entries, power of two, minimum 4.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: input byte present.
REQ-006 The block SHALL have port in_sop, input, 1 bit: first byte of packet; in_data[1:0] carries destination port.
REQ-007 The block SHALL have port in_eop, input, 1 bit: last byte of packet.
REQ-008 The block SHALL have port in_data, input, 8 bits: packet byte.
REQ-009 The block SHALL have port out_valid, output, 1 bit: committed byte available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts byte.
REQ-011 The block SHALL have port out_sop, output, 1 bit: output byte is first of packet.
REQ-012 The block SHALL have port out_eop, output, 1 bit: output byte is last of packet.
REQ-013 The block SHALL have port out_data, output, 8 bits: output byte.
REQ-014 The block SHALL have port pkt_cnt, output, 8 bits: packets committed, saturating.
REQ-015 The block SHALL have port drop_cnt, output, 8 bits: packets dropped for overflow or truncation, saturating.

Function
REQ-016 Input SHALL never backpressure; a packet that cannot be stored SHALL be dropped whole.
REQ-017 Each entry SHALL store {sop, eop, data} (10 bits); the pointers SHALL be log2(DEPTH)+1 bits wide; wr, commit and rd pointers; full = (wr - rd == DEPTH).
REQ-018 Input FSM states SHALL be IDLE, ACCEPT and DISCARD.
REQ-019 In IDLE, in_valid with in_sop=0 SHALL be ignored.
REQ-020 In IDLE, in_valid with in_sop=1 and in_data[1:0] != PORTNO SHALL enter DISCARD (stay in IDLE if in_eop=1); no counter SHALL change.
REQ-021 In IDLE, in_valid with in_sop=1, a matching destination and not full SHALL write the byte and enter ACCEPT; with in_eop=1 as well it SHALL commit and stay in IDLE.
REQ-022 In IDLE, a matching sop while full SHALL increment drop_cnt and enter DISCARD (stay in IDLE if in_eop=1).
REQ-023 In ACCEPT, an in_valid byte when not full SHALL be written; with in_eop it SHALL set commit=wr+1, increment pkt_cnt and go to IDLE.
REQ-024 In ACCEPT, an in_valid byte when full SHALL rewind wr to commit, increment drop_cnt and enter DISCARD (go to IDLE if in_eop).
REQ-025 In ACCEPT, in_sop=1 (missing eop) SHALL rewind wr to commit and increment drop_cnt, then process the byte as a new sop under the IDLE rules in the same cycle.
REQ-026 DISCARD SHALL ignore bytes until in_eop and then go to IDLE; an in_sop in DISCARD SHALL be processed under the IDLE rules.
REQ-027 Full SHALL be evaluated from pre-cycle pointers; a read in the same cycle SHALL NOT free space for that cycle's write.
REQ-028 out_valid SHALL equal (rd != commit); out_sop, out_eop and out_data SHALL be the entry at rd (first-word fall-through).
REQ-029 Uncommitted bytes SHALL never appear on the output.
REQ-030 On out_valid & out_ready, rd SHALL increment.
REQ-031 An eop accepted in cycle N SHALL make its packet's first byte visible with out_valid=1 in cycle N+1.
REQ-032 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-033 A packet longer than DEPTH bytes SHALL always drop.
REQ-034 Pointers SHALL wrap modulo 2*DEPTH.
REQ-035 Counters SHALL saturate at 255.

Reset
REQ-036 rst SHALL set wr=commit=rd=0, FSM=IDLE, pkt_cnt=0 and drop_cnt=0; out_valid SHALL be 0 in the cycle following rst.
REQ-037 Reset asserted mid-packet SHALL discard all stored and partial data without counting a drop.
REQ-038 Storage contents SHALL need no reset.

Structure
REQ-039 Package pds_pkg SHALL hold the byte-width constant, the state enum (IDLE, ACCEPT, DISCARD) and the entry struct {sop, eop, data}.
REQ-040 Sub-module pds_buf_ram SHALL provide DEPTH x 10 storage with one synchronous write port and one asynchronous read port.

Verification
REQ-041 The bench SHALL check: PORTNO=1, 4-byte packet dest 1 (A1 22 33 44), out_ready=1 -> out_valid the cycle after eop, bytes A1 22 33 44 with sop on first and eop on last, pkt_cnt=1.
REQ-042 The bench SHALL check: 3-byte packet dest 2 -> no output, pkt_cnt=0, drop_cnt=0.
REQ-043 The bench SHALL check: DEPTH=16, out_ready=0, 10-byte packet then 8-byte packet (dest 1) -> first committed, second dropped, drop_cnt=1; after drain only the 10 bytes appear.
REQ-044 The bench SHALL check: 5 bytes of a packet then a new sop without eop, then a 2-byte packet -> drop_cnt=1, pkt_cnt=1, output has only the 2-byte packet.
REQ-045 The bench SHALL check: rst asserted for 1 cycle in the middle of a packet with 2 committed packets queued -> out_valid=0 next cycle, pkt_cnt=0, drop_cnt=0, and the next packet passes normally.
REQ-046 The bench SHALL check: 300 single-byte packets with out_ready=1 -> pkt_cnt saturates at 255, and all 300 bytes are output in order across pointer wrap.
